// File: rtl/fxp_div_seq_v2.sv
// Serial signed fixed-point divider: restoring division, UNROLL quotient bits per cycle,
// optional round-half-away, saturation and divide-by-zero handling behind valid/ready handshakes.
module fxp_div_seq_v2 #(
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned AFBITS = 7,
  parameter int unsigned BWIDTH = 12,
  parameter int unsigned BFBITS = 0,
  parameter int unsigned QWIDTH = 14,
  parameter int unsigned QFBITS = 7,
  parameter int unsigned UNROLL = 1,
  parameter int unsigned TAGW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [BWIDTH-1:0] b,
  input  logic              rnd,
  input  logic [TAGW-1:0]   tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [QWIDTH-1:0] q,
  output logic [TAGW-1:0]   tag_out,
  output logic              dz,
  output logic              ovf
);
  localparam int unsigned SHIFT = QFBITS + BFBITS - AFBITS;
  localparam int unsigned NW    = WIDTH + SHIFT;
  localparam int unsigned RW    = BWIDTH + 1;
  localparam int unsigned CW    = $clog2(NW + UNROLL + 1);
  localparam int unsigned MW    = ((NW + 1 > QWIDTH) ? NW + 1 : QWIDTH) + 1;

  localparam logic [MW-1:0]     POS_LIM = MW'((64'd1 << (QWIDTH - 1)) - 64'd1);
  localparam logic [MW-1:0]     NEG_LIM = MW'(64'd1 << (QWIDTH - 1));
  localparam logic [QWIDTH-1:0] QMAX    = {1'b0, {(QWIDTH - 1){1'b1}}};
  localparam logic [QWIDTH-1:0] QMIN    = {1'b1, {(QWIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN, OUT} state_t;

  state_t            state;
  logic [NW-1:0]     n_r;
  logic [RW-1:0]     rem_r;
  logic [BWIDTH-1:0] den_r;
  logic [CW-1:0]     step_r;
  logic              sgn_r;
  logic              aneg_r;
  logic              zero_r;
  logic              rnd_r;
  logic [TAGW-1:0]   tag_r;

  logic [WIDTH-1:0]  a_abs;
  logic [BWIDTH-1:0] b_abs;

  // Magnitudes at full operand width so the most-negative value maps to 2^(W-1).
  assign a_abs = a[WIDTH-1] ? WIDTH'(-a) : a;
  assign b_abs = b[BWIDTH-1] ? BWIDTH'(-b) : b;

  // One CALC cycle: up to UNROLL restoring sub-steps; n_r shifts the dividend out and the quotient in.
  logic [NW-1:0] n_nx;
  logic [RW-1:0] rem_nx;
  logic [RW-1:0] trial;
  always_comb begin
    n_nx   = n_r;
    rem_nx = rem_r;
    trial  = '0;
    for (int u = 0; u < UNROLL; u++) begin
      if (CW'(u) + step_r < CW'(NW)) begin
        trial = {rem_nx[RW-2:0], n_nx[NW-1]};
        n_nx  = {n_nx[NW-2:0], 1'b0};
        if (trial >= {1'b0, den_r}) begin
          rem_nx  = trial - {1'b0, den_r};
          n_nx[0] = 1'b1;
        end else begin
          rem_nx = trial;
        end
      end
    end
  end

  // Result shaping for FIN: rounding, sign, saturation and divide-by-zero override.
  logic [MW-1:0]     qm;
  logic [QWIDTH-1:0] q_fin;
  logic              ovf_fin;
  logic              neg;
  always_comb begin
    qm = MW'(n_r);
    if (rnd_r && ({rem_r, 1'b0} >= {2'b00, den_r})) qm = qm + MW'(1);
    neg     = sgn_r && (qm != '0);
    q_fin   = QWIDTH'(qm);
    ovf_fin = 1'b0;
    if (zero_r) begin
      q_fin = aneg_r ? QMIN : QMAX;
    end else if (!neg) begin
      if (qm > POS_LIM) begin
        q_fin   = QMAX;
        ovf_fin = 1'b1;
      end
    end else if (qm > NEG_LIM) begin
      q_fin   = QMIN;
      ovf_fin = 1'b1;
    end else begin
      q_fin = QWIDTH'(MW'(0) - qm);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      q         <= '0;
      tag_out   <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      n_r       <= '0;
      rem_r     <= '0;
      den_r     <= '0;
      step_r    <= '0;
      sgn_r     <= 1'b0;
      aneg_r    <= 1'b0;
      zero_r    <= 1'b0;
      rnd_r     <= 1'b0;
      tag_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            n_r      <= NW'(a_abs) << SHIFT;
            rem_r    <= '0;
            den_r    <= b_abs;
            step_r   <= '0;
            sgn_r    <= a[WIDTH-1] ^ b[BWIDTH-1];
            aneg_r   <= a[WIDTH-1];
            zero_r   <= (b == '0);
            rnd_r    <= rnd;
            tag_r    <= tag_in;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          n_r    <= n_nx;
          rem_r  <= rem_nx;
          step_r <= step_r + CW'(UNROLL);
          if (step_r + CW'(UNROLL) >= CW'(NW)) state <= FIN;
        end
        FIN: begin
          q         <= q_fin;
          ovf       <= ovf_fin;
          dz        <= zero_r;
          tag_out   <= tag_r;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fxp_div_seq_v2.sv
// Bench for fxp_div_seq_v2: directed scenarios plus randomized operands against an
// integer-arithmetic reference, on a default instance and an UNROLL=4 / BFBITS=4 instance.
module tb_fxp_div_seq_v2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // default instance
  logic        iv0, ir0, rnd0, ov0, or0, dz0, ovf0;
  logic [13:0] a0, q0;
  logic [11:0] b0;
  logic [3:0]  ti0, to0;

  // UNROLL=4, BFBITS=4 instance
  logic        iv4, ir4, rnd4, ov4, or4, dz4, ovf4;
  logic [13:0] a4, q4;
  logic [11:0] b4;
  logic [3:0]  ti4, to4;

  fxp_div_seq_v2 #(
    .WIDTH(14), .AFBITS(7), .BWIDTH(12), .BFBITS(0),
    .QWIDTH(14), .QFBITS(7), .UNROLL(1), .TAGW(4)
  ) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .rnd(rnd0),
    .tag_in(ti0), .out_valid(ov0), .out_ready(or0), .q(q0), .tag_out(to0), .dz(dz0), .ovf(ovf0)
  );

  fxp_div_seq_v2 #(
    .WIDTH(14), .AFBITS(7), .BWIDTH(12), .BFBITS(4),
    .QWIDTH(14), .QFBITS(7), .UNROLL(4), .TAGW(4)
  ) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .rnd(rnd4),
    .tag_in(ti4), .out_valid(ov4), .out_ready(or4), .q(q4), .tag_out(to4), .dz(dz4), .ovf(ovf4)
  );

  // Reference: exact integer quotient of the aligned magnitudes, then round, sign, clamp.
  function automatic void model(input longint av, input longint bv, input bit r,
                                input int shift, input int qw,
                                output longint qv, output bit dzv, output bit ovfv);
    longint am, bm, n, qm, rm, pmax, nmag;
    bit neg;
    am   = (av < 0) ? -av : av;
    bm   = (bv < 0) ? -bv : bv;
    pmax = (longint'(1) <<< (qw - 1)) - 1;
    nmag = pmax + 1;
    dzv  = 1'b0;
    ovfv = 1'b0;
    if (bm == 0) begin
      dzv = 1'b1;
      qv  = (av < 0) ? -nmag : pmax;
      return;
    end
    n  = am << shift;
    qm = n / bm;
    rm = n % bm;
    if (r && (2 * rm >= bm)) qm = qm + 1;
    neg = ((av < 0) != (bv < 0)) && (qm != 0);
    if (!neg) begin
      if (qm > pmax) begin qv = pmax; ovfv = 1'b1; end
      else qv = qm;
    end else begin
      if (qm > nmag) begin qv = -nmag; ovfv = 1'b1; end
      else qv = -qm;
    end
  endfunction

  // Issue one operation on dut0, return edges from accept to out_valid, then consume the result.
  task automatic op0(input logic [13:0] ai, input logic [11:0] bi, input logic r,
                     input logic [3:0] t, output int lat);
    int g;
    @(negedge clk);
    a0 = ai; b0 = bi; rnd0 = r; ti0 = t; iv0 = 1'b1;
    g = 0;
    while (ir0 !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    iv0 = 1'b0;
    lat = 0;
    while (ov0 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    @(negedge clk); or0 = 1'b1;
    @(posedge clk); #1; or0 = 1'b0;
  endtask

  task automatic op4(input logic [13:0] ai, input logic [11:0] bi, input logic r,
                     input logic [3:0] t, output int lat);
    int g;
    @(negedge clk);
    a4 = ai; b4 = bi; rnd4 = r; ti4 = t; iv4 = 1'b1;
    g = 0;
    while (ir4 !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    iv4 = 1'b0;
    lat = 0;
    while (ov4 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    @(negedge clk); or4 = 1'b1;
    @(posedge clk); #1; or4 = 1'b0;
  endtask

  task automatic test_reset;
    n_tests++;
    if ({ir0, ov0, q0, to0, dz0, ovf0} !== {1'b1, 1'b0, 14'd0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset0: in_ready=%b out_valid=%b q=%h tag=%h dz=%b ovf=%b, want 1 0 0 0 0 0",
               ir0, ov0, q0, to0, dz0, ovf0);
    end
    n_tests++;
    if ({ir4, ov4, q4, to4, dz4, ovf4} !== {1'b1, 1'b0, 14'd0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset4: in_ready=%b out_valid=%b q=%h tag=%h dz=%b ovf=%b, want 1 0 0 0 0 0",
               ir4, ov4, q4, to4, dz4, ovf4);
    end
  endtask

  task automatic test_basic;
    int lat;
    logic [13:0] e;
    op0(14'd448, 12'd2, 1'b0, 4'd5, lat);
    n_tests++;
    if (q0 !== 14'd224 || to0 !== 4'd5 || dz0 !== 1'b0 || ovf0 !== 1'b0 || ov0 !== 1'b0 || lat != 15) begin
      n_fail++;
      $display("FAIL basic_pos: q=%0d tag=%0d dz=%b ovf=%b ov=%b lat=%0d, want 224 5 0 0 0 15",
               $signed(q0), to0, dz0, ovf0, ov0, lat);
    end
    e = 14'(-224);
    op0(14'd448, 12'(-2), 1'b0, 4'd6, lat);
    n_tests++;
    if (q0 !== e || to0 !== 4'd6 || dz0 !== 1'b0 || ovf0 !== 1'b0 || lat != 15) begin
      n_fail++;
      $display("FAIL basic_negb: q=%0d tag=%0d dz=%b ovf=%b lat=%0d, want -224 6 0 0 15",
               $signed(q0), to0, dz0, ovf0, lat);
    end
  endtask

  task automatic test_rounding;
    int ta[4] = '{2, 2, -2, 1};
    int tr[4] = '{0, 1, 1, 1};
    int te[4] = '{0, 1, -1, 0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      op0(14'(ta[i]), 12'd3, 1'(tr[i]), 4'(i + 8), lat);
      n_tests++;
      if (q0 !== 14'(te[i]) || to0 !== 4'(i + 8) || ovf0 !== 1'b0 || lat != 15) begin
        n_fail++;
        $display("FAIL round_%0d: a=%0d rnd=%0d q=%0d tag=%0d ovf=%b lat=%0d, want q=%0d tag=%0d ovf=0 lat=15",
                 i, ta[i], tr[i], $signed(q0), to0, ovf0, lat, te[i], i + 8);
      end
    end
  endtask

  task automatic test_range;
    int ta[4]  = '{-8192, -8192, 448, -1};
    int tb_[4] = '{1, -1, 0, 0};
    int te[4]  = '{-8192, 8191, 8191, -8192};
    int tz[4]  = '{0, 0, 1, 1};
    int to_[4] = '{0, 1, 0, 0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      op0(14'(ta[i]), 12'(tb_[i]), 1'b0, 4'(i), lat);
      n_tests++;
      if (q0 !== 14'(te[i]) || dz0 !== 1'(tz[i]) || ovf0 !== 1'(to_[i]) || lat != 15) begin
        n_fail++;
        $display("FAIL range_%0d: a=%0d b=%0d q=%0d dz=%b ovf=%b lat=%0d, want q=%0d dz=%0d ovf=%0d lat=15",
                 i, ta[i], tb_[i], $signed(q0), dz0, ovf0, lat, te[i], tz[i], to_[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    @(negedge clk);
    a0 = 14'd448; b0 = 12'd2; rnd0 = 1'b0; ti0 = 4'd9; iv0 = 1'b1; or0 = 1'b0;
    @(posedge clk); #1;
    a0 = 14'd100; ti0 = 4'd3;
    lat = 0;
    while (ov0 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    n_tests++;
    if (lat != 15) begin
      n_fail++;
      $display("FAIL bp_latency: lat=%0d, want 15", lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (ov0 !== 1'b1 || ir0 !== 1'b0 || q0 !== 14'd224 || to0 !== 4'd9) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: ov=%b in_ready=%b q=%0d tag=%0d, want 1 0 224 9",
                 i, ov0, ir0, $signed(q0), to0);
      end
    end
    or0 = 1'b1;
    @(posedge clk); #1;
    iv0 = 1'b0; or0 = 1'b0;
    n_tests++;
    if (ov0 !== 1'b0 || ir0 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: ov=%b in_ready=%b, want 0 1", ov0, ir0);
    end
    @(posedge clk); #1;
    n_tests++;
    if (ir0 !== 1'b1 || ov0 !== 1'b0 || q0 !== 14'd224 || to0 !== 4'd9) begin
      n_fail++;
      $display("FAIL bp_idle: in_ready=%b ov=%b q=%0d tag=%0d, want 1 0 224 9",
               ir0, ov0, $signed(q0), to0);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int g;
    @(negedge clk);
    a0 = 14'd448; b0 = 12'd3; rnd0 = 1'b0; ti0 = 4'hA; iv0 = 1'b1;
    @(posedge clk); #1;
    iv0 = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({ir0, ov0, q0, to0, dz0, ovf0} !== {1'b1, 1'b0, 14'd0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b q=%h tag=%h dz=%b ovf=%b, want 1 0 0 0 0 0",
               ir0, ov0, q0, to0, dz0, ovf0);
    end
    rst = 1'b0;
    g = 0;
    repeat (20) begin @(posedge clk); #1; if (ov0 === 1'b1) g++; end
    n_tests++;
    if (g != 0) begin
      n_fail++;
      $display("FAIL reset_mid_noresult: out_valid high for %0d cycles, want 0", g);
    end
    op0(14'd256, 12'd4, 1'b0, 4'd3, lat);
    n_tests++;
    if (q0 !== 14'd64 || to0 !== 4'd3 || dz0 !== 1'b0 || ovf0 !== 1'b0 || lat != 15) begin
      n_fail++;
      $display("FAIL reset_mid_next: q=%0d tag=%0d dz=%b ovf=%b lat=%0d, want 64 3 0 0 15",
               $signed(q0), to0, dz0, ovf0, lat);
    end
  endtask

  task automatic test_unroll4;
    int lat;
    logic [13:0] e;
    op4(14'd448, 12'd40, 1'b0, 4'd6, lat);
    n_tests++;
    if (q4 !== 14'd179 || to4 !== 4'd6 || dz4 !== 1'b0 || ovf4 !== 1'b0 || lat != 6) begin
      n_fail++;
      $display("FAIL u4_basic: q=%0d tag=%0d dz=%b ovf=%b lat=%0d, want 179 6 0 0 6",
               $signed(q4), to4, dz4, ovf4, lat);
    end
    e = 14'(-179);
    op4(14'(-448), 12'd40, 1'b1, 4'd1, lat);
    n_tests++;
    if (q4 !== e || to4 !== 4'd1 || ovf4 !== 1'b0 || lat != 6) begin
      n_fail++;
      $display("FAIL u4_neg_round: q=%0d tag=%0d ovf=%b lat=%0d, want -179 1 0 6",
               $signed(q4), to4, ovf4, lat);
    end
  endtask

  task automatic test_back_to_back;
    int times[$];
    @(negedge clk);
    a4 = 14'd448; b4 = 12'd40; rnd4 = 1'b0; ti4 = 4'd7; iv4 = 1'b1; or4 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov4 === 1'b1) begin
        times.push_back(cyc);
        n_tests++;
        if (q4 !== 14'd179 || to4 !== 4'd7) begin
          n_fail++;
          $display("FAIL b2b_value: q=%0d tag=%0d, want 179 7", $signed(q4), to4);
        end
      end
    end
    iv4 = 1'b0;
    repeat (10) @(posedge clk);
    #1 or4 = 1'b0;
    n_tests++;
    if (times.size() != 5) begin
      n_fail++;
      $display("FAIL b2b_count: results=%0d, want 5", times.size());
    end
    for (int i = 1; i < times.size(); i++) begin
      n_tests++;
      if (times[i] - times[i-1] != 8) begin
        n_fail++;
        $display("FAIL b2b_spacing_%0d: spacing=%0d, want 8", i, times[i] - times[i-1]);
      end
    end
  endtask

  task automatic test_random(input bit use4, input int count);
    logic [13:0] ai;
    logic [11:0] bi;
    logic [3:0]  t;
    logic        r;
    longint      eq, got;
    bit          edz, eovf;
    logic        gdz, govf;
    logic [3:0]  gtag;
    int          lat, elat;
    for (int i = 0; i < count; i++) begin
      ai = 14'($urandom);
      bi = 12'($urandom);
      r  = 1'($urandom);
      t  = 4'($urandom);
      case (i % 8)
        0: bi = '0;
        1: bi = 12'($urandom_range(1, 7));
        2: bi = 12'(-$urandom_range(1, 7));
        3: ai = 14'h2000;
        default: ;
      endcase
      if (use4) begin
        op4(ai, bi, r, t, lat);
        got = longint'($signed(q4)); gdz = dz4; govf = ovf4; gtag = to4; elat = 6;
        model(longint'($signed(ai)), longint'($signed(bi)), r, 4, 14, eq, edz, eovf);
      end else begin
        op0(ai, bi, r, t, lat);
        got = longint'($signed(q0)); gdz = dz0; govf = ovf0; gtag = to0; elat = 15;
        model(longint'($signed(ai)), longint'($signed(bi)), r, 0, 14, eq, edz, eovf);
      end
      n_tests++;
      if (got != eq || gdz !== edz || govf !== eovf || gtag !== t || lat != elat) begin
        n_fail++;
        $display("FAIL rand%0d_%0d: a=%0d b=%0d rnd=%b q=%0d dz=%b ovf=%b tag=%0d lat=%0d, want q=%0d dz=%b ovf=%b tag=%0d lat=%0d",
                 use4 ? 4 : 1, i, $signed(ai), $signed(bi), r, got, gdz, govf, gtag, lat,
                 eq, edz, eovf, t, elat);
      end
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    iv0 = 1'b0; or0 = 1'b0; a0 = '0; b0 = '0; rnd0 = 1'b0; ti0 = '0;
    iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; rnd4 = 1'b0; ti4 = '0;
    #3;
    test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_basic();
    test_rounding();
    test_range();
    test_backpressure();
    test_reset_mid();
    test_unroll4();
    test_back_to_back();
    test_random(1'b0, 1000);
    test_random(1'b1, 3000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
